fft_butterfly_r2: RTL and testbench

- Radix-2 DIT butterfly stage sitting directly downstream of the complex twiddle multiplier.
- Upstream presents the "upper" sample A to this block in the same cycle it drives B and W into the multiplier. One cycle later, the registered product W·B arrives on wb_*.
- The block time-aligns A with W·B, computes X0 = A + W·B and X1 = A − W·B, optionally scales and saturates, and buffers results in a credit-controlled output FIFO toward the next stage or memory writeback.

---
 rtl/fft_butterfly_r2.sv | 129 ++++++++++++
 tb/tb_fft_butterfly_r2.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2
//   Radix-2 DIT butterfly placed right after the complex twiddle multiplier.
//   The upper sample A is captured when a butterfly is accepted. The product
//   W*B shows up on wb_* exactly one cycle later. The block then forms
//   X0 = A + W*B and X1 = A - W*B, and either halves or saturates each
//   component. Every result is written into a small output FIFO.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   upstream handshake (A valid, B/W entering multiplier)
//     a_re, a_im            upper sample A, two's complement
//     wb_re, wb_im          multiplier product, valid one cycle after accept
//     out_valid / out_ready FIFO head handshake toward the next stage
//     x0_re .. x1_im        FIFO head butterfly outputs (zero while empty)
//     ovf, ovf_clr          sticky saturation flag and its synchronous clear
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready depends only on registered state, so it has no path
//   from out_ready. Its credit counts the product still in flight, which
//   means the non-stallable multiplier always finds a free FIFO slot.
module fft_butterfly_r2 #(
  parameter int DEPTH = 4,
  parameter int SCALE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] wb_re,
  input  logic [31:0] wb_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x0_re,
  output logic [31:0] x0_im,
  output logic [31:0] x1_re,
  output logic [31:0] x1_im,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]  a_dly_re, a_dly_im;
  logic         pending;
  logic [127:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic         ovf_q;

  logic accept, push, pop;
  logic [CW:0] credit_used;

  assign credit_used = {1'b0, count} + {{CW{1'b0}}, pending};
  assign in_ready    = credit_used < (CW + 1)'(DEPTH);
  assign accept      = in_valid && in_ready;
  // The product cannot be stalled. It is written in the cycle after accept.
  assign push        = pending;
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;

  // Returns {saturated, value}. The scaled form keeps bits [32:1], which is
  // a floor division by 2 and cannot overflow.
  function automatic logic [32:0] fold(input logic [32:0] v);
    if (SCALE != 0) return {1'b0, v[32:1]};
    if (v[32] != v[31]) return {1'b1, (v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    return {1'b0, v[31:0]};
  endfunction

  logic [32:0] s_x0_re, s_x0_im, s_x1_re, s_x1_im;
  logic [32:0] f_x0_re, f_x0_im, f_x1_re, f_x1_im;
  logic [127:0] result;
  logic         sat_any;

  always_comb begin
    s_x0_re = {a_dly_re[31], a_dly_re} + {wb_re[31], wb_re};
    s_x0_im = {a_dly_im[31], a_dly_im} + {wb_im[31], wb_im};
    s_x1_re = {a_dly_re[31], a_dly_re} - {wb_re[31], wb_re};
    s_x1_im = {a_dly_im[31], a_dly_im} - {wb_im[31], wb_im};
    f_x0_re = fold(s_x0_re);
    f_x0_im = fold(s_x0_im);
    f_x1_re = fold(s_x1_re);
    f_x1_im = fold(s_x1_im);
    result  = {f_x0_re[31:0], f_x0_im[31:0], f_x1_re[31:0], f_x1_im[31:0]};
    sat_any = f_x0_re[32] | f_x0_im[32] | f_x1_re[32] | f_x1_im[32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dly_re <= '0;
      a_dly_im <= '0;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_dly_re <= a_re;
        a_dly_im <= a_im;
      end
      // The in-flight product retires every cycle, so pending simply tracks
      // whether this edge started a new one.
      pending <= accept;
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A saturation in the same cycle wins over a clear.
      if (push && sat_any) ovf_q <= 1'b1;
      else if (ovf_clr)    ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset. The head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  assign {x0_re, x0_im, x1_re, x1_im} = out_valid ? mem[rd_ptr] : 128'd0;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_r2.sv
module tb_fft_butterfly_r2;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clr = 1'b0;
  logic [31:0] a_re = '0, a_im = '0, wb_re = '0, wb_im = '0;

  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [31:0] x0_re0, x0_im0, x1_re0, x1_im0;
  logic [31:0] x0_re1, x0_im1, x1_re1, x1_im1;
  logic [127:0] obs0, obs1;

  assign obs0 = {x0_re0, x0_im0, x1_re0, x1_im0};
  assign obs1 = {x0_re1, x0_im1, x1_re1, x1_im1};

  always #5 clk = ~clk;

  fft_butterfly_r2 #(.DEPTH(4), .SCALE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .wb_re(wb_re), .wb_im(wb_im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .x0_re(x0_re0), .x0_im(x0_im0), .x1_re(x1_re0), .x1_im(x1_im0),
    .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  fft_butterfly_r2 #(.DEPTH(4), .SCALE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .wb_re(wb_re), .wb_im(wb_im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .x0_re(x0_re1), .x0_im(x0_im1), .x1_re(x1_re1), .x1_im(x1_im1),
    .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_pop = 0;
  int cur_run = 0;
  int max_run = 0;
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  logic [127:0] pend0, pend1;
  logic pend_v = 1'b0;
  logic pend_sat = 1'b0;
  logic ovf_m = 1'b0;

  // ---------------- reference model ----------------
  // One component: {saturated, value} from plain integer arithmetic.
  function automatic logic [32:0] ref_comp(input logic [31:0] a, input logic [31:0] b,
                                           input bit sub, input int scale);
    longint s;
    s = sub ? (longint'($signed(a)) - longint'($signed(b)))
            : (longint'($signed(a)) + longint'($signed(b)));
    if (scale != 0) return {1'b0, 32'(s >>> 1)};
    if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'(s)};
  endfunction

  function automatic logic [128:0] ref_bfly(input logic [31:0] ar, input logic [31:0] ai,
                                            input logic [31:0] br, input logic [31:0] bi,
                                            input int scale);
    logic [32:0] c0, c1, c2, c3;
    c0 = ref_comp(ar, br, 1'b0, scale);
    c1 = ref_comp(ai, bi, 1'b0, scale);
    c2 = ref_comp(ar, br, 1'b1, scale);
    c3 = ref_comp(ai, bi, 1'b1, scale);
    return {c0[32] | c1[32] | c2[32] | c3[32], c0[31:0], c1[31:0], c2[31:0], c3[31:0]};
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Called just after a rising edge. It presents A, checks the outputs at the
  // falling edge, and advances the model through the next rising edge. The
  // product (br, bi) is driven in the cycle after the accept.
  task automatic step(input logic v, input logic [31:0] ar, input logic [31:0] ai,
                      input logic [31:0] br, input logic [31:0] bi);
    logic acc, do_pop, clr, rst_s, exp_rdy;
    logic [127:0] h0, h1;
    logic [128:0] r0, r1;
    in_valid = v;
    a_re = ar;
    a_im = ai;
    @(negedge clk);
    rst_s = rst_n;
    exp_rdy = (exp_q0.size() + int'(pend_v)) < 4;
    h0 = (exp_q0.size() != 0) ? exp_q0[0] : 128'd0;
    h1 = (exp_q1.size() != 0) ? exp_q1[0] : 128'd0;
    n_tests++; if (in_ready0 !== exp_rdy) begin n_fail++; $display("FAIL in_ready0: got %b expected %b", in_ready0, exp_rdy); end
    n_tests++; if (in_ready1 !== exp_rdy) begin n_fail++; $display("FAIL in_ready1: got %b expected %b", in_ready1, exp_rdy); end
    n_tests++; if (out_valid0 !== (exp_q0.size() != 0)) begin n_fail++; $display("FAIL out_valid0: got %b expected %b", out_valid0, exp_q0.size() != 0); end
    n_tests++; if (out_valid1 !== (exp_q1.size() != 0)) begin n_fail++; $display("FAIL out_valid1: got %b expected %b", out_valid1, exp_q1.size() != 0); end
    n_tests++; if (obs0 !== h0) begin n_fail++; $display("FAIL head_s0: got %h expected %h", obs0, h0); end
    n_tests++; if (obs1 !== h1) begin n_fail++; $display("FAIL head_s1: got %h expected %h", obs1, h1); end
    n_tests++; if (ovf0 !== ovf_m) begin n_fail++; $display("FAIL ovf_s0: got %b expected %b", ovf0, ovf_m); end
    n_tests++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_s1: got %b expected 0", ovf1); end
    if (out_valid0 === 1'b1) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    acc = v && exp_rdy && rst_s;
    do_pop = rst_s && out_ready && (exp_q0.size() != 0);
    clr = ovf_clr;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      exp_q0.delete();
      exp_q1.delete();
      pend_v = 1'b0;
      ovf_m = 1'b0;
    end else begin
      if (do_pop) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
        n_pop++;
      end
      if (pend_v) begin
        exp_q0.push_back(pend0);
        exp_q1.push_back(pend1);
      end
      if (pend_v && pend_sat) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      pend_v = acc;
      if (acc) begin
        r0 = ref_bfly(ar, ai, br, bi, 0);
        r1 = ref_bfly(ar, ai, br, bi, 1);
        pend0 = r0[127:0];
        pend1 = r1[127:0];
        pend_sat = r0[128];
        n_acc++;
      end
    end
    if (acc) begin
      wb_re = br;
      wb_im = bi;
    end else begin
      wb_re = $urandom;
      wb_im = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q0.size() != 0 || pend_v); i++) idle(1);
    n_tests++;
    if (exp_q0.size() != 0 || pend_v) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q0.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid0); end
    n_tests++; if (obs0 !== 128'd0 || obs1 !== 128'd0) begin n_fail++; $display("FAIL rst_x: got %h expected 0", obs0); end
    n_tests++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", ovf0); end
    n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready0); end
    rst_n = 1'b1;
    idle(3);
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL post_rst_write: got %b expected 0", out_valid0); end
  endtask

  task automatic test_basic();
    step(1'b1, 32'd100, 32'hFFFF_FFCE, 32'd30, 32'd20);
    step(1'b0, '0, '0, '0, '0);
    n_tests++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid0); end
    n_tests++; if (obs0 !== {32'd130, 32'hFFFF_FFE2, 32'd70, 32'hFFFF_FFBA}) begin n_fail++; $display("FAIL basic_s0: got %h", obs0); end
    n_tests++; if (obs1 !== {32'd65, 32'hFFFF_FFF1, 32'd35, 32'hFFFF_FFDD}) begin n_fail++; $display("FAIL basic_s1: got %h", obs1); end
    drain();
  endtask

  task automatic test_saturation();
    step(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd1);
    step(1'b0, '0, '0, '0, '0);
    n_tests++; if (obs0 !== {32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h8000_0000}) begin n_fail++; $display("FAIL sat_s0: got %h", obs0); end
    n_tests++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", ovf0); end
    n_tests++; if (x0_re1 !== 32'h4000_0000 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL sat_s1: got %h ovf %b expected 40000000 ovf 0", x0_re1, ovf1); end
    ovf_clr = 1'b1;
    step(1'b0, '0, '0, '0, '0);
    ovf_clr = 1'b0;
    n_tests++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf0); end
    // Clear asserted during a saturating write: the set wins.
    ovf_clr = 1'b1;
    step(1'b1, 32'h7FFF_FFFF, 32'd0, 32'd5, 32'd0);
    step(1'b0, '0, '0, '0, '0);
    ovf_clr = 1'b0;
    n_tests++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_set_prio: got %b expected 1", ovf0); end
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    drain();
  endtask

  task automatic test_scaling();
    step(1'b1, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0);
    step(1'b0, '0, '0, '0, '0);
    n_tests++; if (x0_re1 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL floor_s1: got %h expected fffffffe", x0_re1); end
    n_tests++; if (x0_re0 !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL floor_s0: got %h expected fffffffd", x0_re0); end
    drain();
  endtask

  task automatic test_backpressure();
    int acc0, pop0;
    acc0 = n_acc;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, $urandom, $urandom, $urandom);
    n_tests++; if (n_acc - acc0 != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", n_acc - acc0); end
    n_tests++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready0); end
    pop0 = n_pop;
    out_ready = 1'b1;
    idle(8);
    n_tests++; if (n_pop - pop0 != 4) begin n_fail++; $display("FAIL bp_pops: got %0d expected 4", n_pop - pop0); end
  endtask

  task automatic test_back_to_back();
    int acc0, pop0;
    drain();
    acc0 = n_acc;
    pop0 = n_pop;
    cur_run = 0;
    max_run = 0;
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, $urandom, $urandom, $urandom);
    idle(4);
    n_tests++; if (n_acc - acc0 != 16) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 16", n_acc - acc0); end
    n_tests++; if (n_pop - pop0 != 16) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 16", n_pop - pop0); end
    n_tests++; if (max_run != 16) begin n_fail++; $display("FAIL b2b_run: got %0d expected 16", max_run); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, $urandom, $urandom, $urandom);
    rst_n = 1'b0;
    #1;
    exp_q0.delete();
    exp_q1.delete();
    pend_v = 1'b0;
    ovf_m = 1'b0;
    n_tests++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b%b expected 00", out_valid0, out_valid1); end
    n_tests++; if (obs0 !== 128'd0) begin n_fail++; $display("FAIL mid_rst_x: got %h expected 0", obs0); end
    n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready0); end
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, $urandom, $urandom, $urandom);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale: got %b expected 0", out_valid0); end
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, $urandom, $urandom, $urandom);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] ar, br;
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      ovf_clr = 1'($urandom_range(0, 7) == 0);
      ar = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + $urandom_range(0, 15) : $urandom;
      br = $urandom;
      step(1'($urandom_range(0, 1)), ar, $urandom, br, $urandom);
    end
    ovf_clr = 1'b0;
    drain();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_scaling();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
